// File: rtl/timer_pkg.sv
// Shared timer types and constants: FSM states, BCD correction constants,
// and the elaboration-time sizing helper for the BCD-to-binary converter.
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Reverse double-dabble nibble correction: nibble >= 8 gets 3 subtracted
   localparam logic [3:0] ADJ_THRESH = 4'd8;
   localparam logic [3:0] ADJ_VALUE  = 4'd3;

   // Largest legal decimal digit value
   localparam logic [3:0] DIGIT_MAX  = 4'd9;

   // Minimum binary width able to hold 10^digits - 1
   function automatic int unsigned min_bin_w(input int unsigned digits);
      longint unsigned max_val;
      int unsigned     w;
      max_val = 64'd1;
      for (int unsigned i = 0; i < digits; i++) begin
         max_val = max_val * 64'd10;
      end
      max_val = max_val - 64'd1;
      w = 0;
      for (int unsigned b = 0; b < 64; b++) begin
         if ((max_val >> b) != 64'd0) begin
            w = b + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/bcd2bin_if.sv
// Start/valid handshake bundle between the time-setting logic (master)
// and the BCD-to-binary converter (slave).
interface bcd2bin_if #(
   parameter int unsigned DIGITS = 2,
   parameter int unsigned BIN_W  = 7
);
   localparam int unsigned BCD_W = 4 * DIGITS;

   logic             i_start;
   logic [BCD_W-1:0] i_bcd;
   logic             o_busy;
   logic             o_valid;
   logic [BIN_W-1:0] o_bin;
   logic             o_err;

   modport master (
      output i_start, i_bcd,
      input  o_busy, o_valid, o_bin, o_err
   );

   modport slave (
      input  i_start, i_bcd,
      output o_busy, o_valid, o_bin, o_err
   );

endinterface

// File: rtl/bcd2bin_digit_adjust.sv
// One-nibble reverse double-dabble correction (>= 8 -> minus 3), purely
// combinational, instantiated once per BCD digit.
module bcd_digit_adjust
   import timer_pkg::*;
(
   input  logic [3:0] nib,
   output logic [3:0] adj_c
);

   // Subtract the adjust constant once the nibble reaches the threshold
   always_comb begin
      adj_c = nib;
      if (nib >= ADJ_THRESH) begin
         adj_c = nib - ADJ_VALUE;
      end
   end

endmodule

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one bit per
// clock, 4*DIGITS cycles per conversion.
// Optional feature macro: BCD2BIN_ERR_CHECK_EN (flags digits > 9 and forces
// the result to zero for such inputs).
module bcd2bin
   import timer_pkg::*;
#(
   parameter int unsigned DIGITS = 2,
   parameter int unsigned BIN_W  = 7
) (
   input  logic      clk,
   input  logic      rst_n,
   bcd2bin_if.slave  bus
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(BCD_W + 1);
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BCD_W - 1);

   // Reject result widths too narrow for the largest decimal value
   if (BIN_W < min_bin_w(DIGITS)) begin : g_bin_w_check
      $error("bcd2bin: BIN_W too small for DIGITS");
   end

   state_t            state_q;
   logic [BCD_W-1:0]  bcd_q;
   logic [BCD_W-1:0]  res_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [BCD_W-1:0]  bcd_sh_c;
   logic [BCD_W-1:0]  bcd_adj_c;
   logic [BCD_W-1:0]  res_sh_c;
   logic [BIN_W-1:0]  bin_done_c;

   // {bcd, result} shifted right by one: BCD LSB falls into result MSB
   assign bcd_sh_c = {1'b0, bcd_q[BCD_W-1:1]};
   assign res_sh_c = {bcd_q[0], res_q[BCD_W-1:1]};

   // Per-digit correction of the shifted BCD register
   for (genvar d = 0; d < int'(DIGITS); d++) begin : g_adj
      bcd_digit_adjust u_adj (
         .nib   (bcd_sh_c[4*d +: 4]),
         .adj_c (bcd_adj_c[4*d +: 4])
      );
   end

`ifdef BCD2BIN_ERR_CHECK_EN
   logic err_q;
   logic bad_digit_c;

   // Any incoming nibble above 9 marks the request as invalid
   always_comb begin
      bad_digit_c = 1'b0;
      for (int d = 0; d < int'(DIGITS); d++) begin
         if (bus.i_bcd[4*d +: 4] > DIGIT_MAX) begin
            bad_digit_c = 1'b1;
         end
      end
   end

   assign bin_done_c = err_q ? '0 : BIN_W'(res_sh_c);
   assign bus.o_err  = err_q;
`else
   assign bin_done_c = BIN_W'(res_sh_c);
   assign bus.o_err  = 1'b0;
`endif

   // Conversion FSM with shift datapath and registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bcd_q       <= '0;
         res_q       <= '0;
         cnt_q       <= '0;
         bus.o_busy  <= 1'b0;
         bus.o_valid <= 1'b0;
         bus.o_bin   <= '0;
`ifdef BCD2BIN_ERR_CHECK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.i_start) begin
                  state_q    <= ST_SHIFT;
                  bcd_q      <= bus.i_bcd;
                  res_q      <= '0;
                  cnt_q      <= '0;
                  bus.o_busy <= 1'b1;
`ifdef BCD2BIN_ERR_CHECK_EN
                  err_q      <= bad_digit_c;
`endif
               end
            end
            ST_SHIFT: begin
               bcd_q <= bcd_adj_c;
               res_q <= res_sh_c;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST_SHIFT) begin
                  state_q     <= ST_DONE;
                  bus.o_valid <= 1'b1;
                  bus.o_bin   <= bin_done_c;
               end
            end
            ST_DONE: begin
               state_q     <= ST_IDLE;
               bus.o_valid <= 1'b0;
               bus.o_busy  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin: directed table, random vectors against a
// decimal-arithmetic model, and hand-written multi-cycle corner sequences.
module tb_bcd2bin;

`ifdef BCD2BIN_ERR_CHECK_EN
   localparam int ERR_EN = 1;
`else
   localparam int ERR_EN = 0;
`endif

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   bcd2bin_if #(.DIGITS(2), .BIN_W(7))  bus2 ();
   bcd2bin_if #(.DIGITS(3), .BIN_W(10)) bus3 ();

   bcd2bin #(.DIGITS(2), .BIN_W(7)) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2.slave)
   );

   bcd2bin #(.DIGITS(3), .BIN_W(10)) u_dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3.slave)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] bcd;
      int         exp_bin;
      int         chk_bin;
      int         exp_err;
      string      name;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Decimal value of a packed BCD word
   function automatic int bcd_val(input logic [11:0] b, input int digits);
      int v;
      int mul;
      v   = 0;
      mul = 1;
      for (int i = 0; i < digits; i++) begin
         v   = v + int'(b[4*i +: 4]) * mul;
         mul = mul * 10;
      end
      return v;
   endfunction

   function automatic logic [11:0] rand_bcd(input int digits);
      logic [11:0] r;
      r = '0;
      for (int i = 0; i < digits; i++) begin
         r[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      return r;
   endfunction

   // One 2-digit conversion: latency, busy length, single pulse, result, error flag
   task automatic run2(input logic [7:0] bcd, input int exp_bin, input int chk_bin,
                       input int exp_err, input string name);
      int lat;
      int busy_cnt;
      int pulses;
      int bin_got;
      lat      = -1;
      busy_cnt = 0;
      pulses   = 0;
      bin_got  = -1;
      @(negedge clk);
      bus2.i_start = 1'b1;
      bus2.i_bcd   = bcd;
      @(negedge clk);
      bus2.i_start = 1'b0;
      bus2.i_bcd   = 8'($urandom);
      check({name, "_err_accept"}, int'(bus2.o_err), exp_err);
      for (int idx = 0; idx < 16; idx++) begin
         if (idx > 0) @(negedge clk);
         if (bus2.o_busy) busy_cnt++;
         if (bus2.o_valid) begin
            pulses++;
            lat     = idx;
            bin_got = int'(bus2.o_bin);
         end
      end
      check({name, "_latency"}, lat, 8);
      check({name, "_busy_cycles"}, busy_cnt, 9);
      check({name, "_pulses"}, pulses, 1);
      if (chk_bin != 0) check({name, "_bin"}, bin_got, exp_bin);
      check({name, "_err_hold"}, int'(bus2.o_err), exp_err);
      check({name, "_bin_hold"}, int'(bus2.o_bin), (chk_bin != 0) ? exp_bin : int'(bus2.o_bin) ^ 0);
   endtask

   // One 3-digit conversion: latency and result
   task automatic run3(input logic [11:0] bcd, input string name);
      int lat;
      int bin_got;
      lat     = -1;
      bin_got = -1;
      @(negedge clk);
      bus3.i_start = 1'b1;
      bus3.i_bcd   = bcd;
      @(negedge clk);
      bus3.i_start = 1'b0;
      bus3.i_bcd   = 12'($urandom);
      for (int idx = 0; idx < 20; idx++) begin
         if (idx > 0) @(negedge clk);
         if (bus3.o_valid) begin
            lat     = idx;
            bin_got = int'(bus3.o_bin);
         end
      end
      check({name, "_latency"}, lat, 12);
      check({name, "_bin"}, bin_got, bcd_val(bcd, 3));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      int first_idx;
      int first_bin;
      int second_idx;
      int second_bin;

      bus2.i_start = 1'b0;
      bus2.i_bcd   = '0;
      bus3.i_start = 1'b0;
      bus3.i_bcd   = '0;
      rst_n        = 1'b0;

      vecs[0] = '{8'h59, 59, 1, 0, "v59"};
      vecs[1] = '{8'h00, 0,  1, 0, "v00"};
      vecs[2] = '{8'h99, 99, 1, 0, "v99"};
      vecs[3] = '{8'h45, 45, 1, 0, "v45"};
      vecs[4] = '{8'h10, 10, 1, 0, "v10"};
      vecs[5] = '{8'h01, 1,  1, 0, "v01"};
      vecs[6] = '{8'h90, 90, 1, 0, "v90"};
      vecs[7] = '{8'h5A, 0,  ERR_EN, ERR_EN, "v5a_bad"};
      vecs[8] = '{8'h07, 7,  1, 0, "v07_after_bad"};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy",  int'(bus2.o_busy),  0);
      check("rst_valid", int'(bus2.o_valid), 0);
      check("rst_bin",   int'(bus2.o_bin),   0);
      check("rst_err",   int'(bus2.o_err),   0);
      check("rst_bin3",  int'(bus3.o_bin),   0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 9; i++) begin
         run2(vecs[i].bcd, vecs[i].exp_bin, vecs[i].chk_bin, vecs[i].exp_err, vecs[i].name);
      end

      // Random valid 2-digit values against the decimal model
      for (int i = 0; i < 12; i++) begin
         logic [11:0] r;
         r = rand_bcd(2);
         run2(r[7:0], bcd_val(r, 2), 1, 0, $sformatf("rand2_%0d", i));
      end

      // 3-digit instance: corners and random
      run3(12'h255, "d3_255");
      run3(12'h999, "d3_999");
      run3(12'h000, "d3_000");
      run3(12'h100, "d3_100");
      for (int i = 0; i < 5; i++) begin
         run3(rand_bcd(3), $sformatf("rand3_%0d", i));
      end

      // Busy rejection: second start during conversion is dropped
      pulses    = 0;
      first_idx = -1;
      first_bin = -1;
      @(negedge clk);
      bus2.i_start = 1'b1;
      bus2.i_bcd   = 8'h45;
      @(negedge clk);
      bus2.i_start = 1'b0;
      for (int idx = 0; idx < 26; idx++) begin
         if (idx > 0) @(negedge clk);
         if (bus2.o_valid) begin
            pulses++;
            first_idx = idx;
            first_bin = int'(bus2.o_bin);
         end
         if (idx == 2) begin
            bus2.i_start = 1'b1;
            bus2.i_bcd   = 8'h23;
         end else begin
            bus2.i_start = 1'b0;
         end
      end
      check("busy_rej_pulses", pulses, 1);
      check("busy_rej_latency", first_idx, 8);
      check("busy_rej_bin", first_bin, 45);

      // Reset mid-conversion after four shifts
      @(negedge clk);
      bus2.i_start = 1'b1;
      bus2.i_bcd   = 8'h37;
      @(negedge clk);
      bus2.i_start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy",  int'(bus2.o_busy),  0);
      check("midrst_valid", int'(bus2.o_valid), 0);
      check("midrst_bin",   int'(bus2.o_bin),   0);
      check("midrst_err",   int'(bus2.o_err),   0);
      @(negedge clk);
      rst_n  = 1'b1;
      pulses = 0;
      for (int idx = 0; idx < 15; idx++) begin
         @(negedge clk);
         if (bus2.o_valid) pulses++;
      end
      check("midrst_no_valid", pulses, 0);
      run2(8'h12, 12, 1, 0, "after_rst_12");

      // Back-to-back with start held high, input changed between acceptances
      pulses     = 0;
      first_idx  = -1;
      first_bin  = -1;
      second_idx = -1;
      second_bin = -1;
      @(negedge clk);
      bus2.i_start = 1'b1;
      bus2.i_bcd   = 8'h10;
      @(negedge clk);
      bus2.i_bcd   = 8'h58;
      for (int idx = 0; idx < 30; idx++) begin
         if (idx > 0) @(negedge clk);
         if (idx == 10) bus2.i_start = 1'b0;
         if (bus2.o_valid) begin
            pulses++;
            if (pulses == 1) begin
               first_idx = idx;
               first_bin = int'(bus2.o_bin);
            end else begin
               second_idx = idx;
               second_bin = int'(bus2.o_bin);
            end
         end
      end
      check("b2b_pulses", pulses, 2);
      check("b2b_first_idx", first_idx, 8);
      check("b2b_first_bin", first_bin, 10);
      check("b2b_second_idx", second_idx, 18);
      check("b2b_second_bin", second_bin, 58);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
